// File: rtl/spi_frame_loader.sv
// SPI-to-frame-buffer loader: synchronises SPI byte strobes, decodes commands,
// fills the image buffer sequentially and hands it to the edge engine.
module spi_frame_loader #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 48,
   parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic [7:0]        rxData,
   input  logic              rxValid,
   input  logic              csActive,
   input  logic              engineBusy,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [7:0]        memData,
   output logic              engineStart,
   output logic              frameReady,
   output logic              loading,
   output logic              errSticky
);

   localparam int NPIX = IMG_W*IMG_H;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX-1);

   localparam logic [7:0] CMD_LOAD  = 8'hA5;
   localparam logic [7:0] CMD_START = 8'h5A;
   localparam logic [7:0] CMD_CLR   = 8'hC3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_READY,
      S_RUN
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_busySeen;
   logic              r_rxv_s1;
   logic              r_rxv_s2;
   logic              r_rxv_s3;
   logic              r_cs_s1;
   logic              r_cs_s2;
   logic              r_cs_s3;

   logic              w_strobe;
   logic              w_csFall;
   logic              w_isLoad;
   logic              w_isStart;
   logic              w_isClr;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_rxv_s1 <= 1'b0;
         r_rxv_s2 <= 1'b0;
         r_rxv_s3 <= 1'b0;
         r_cs_s1  <= 1'b0;
         r_cs_s2  <= 1'b0;
         r_cs_s3  <= 1'b0;
      end else begin
         r_rxv_s1 <= rxValid;
         r_rxv_s2 <= r_rxv_s1;
         r_rxv_s3 <= r_rxv_s2;
         r_cs_s1  <= csActive;
         r_cs_s2  <= r_cs_s1;
         r_cs_s3  <= r_cs_s2;
      end
   end

   // rxData is held stable by the receiver while rxValid is high
   assign w_strobe  = r_rxv_s2 & ~r_rxv_s3;
   assign w_csFall  = r_cs_s3 & ~r_cs_s2;
   assign w_isLoad  = w_strobe && (rxData == CMD_LOAD);
   assign w_isStart = w_strobe && (rxData == CMD_START);
   assign w_isClr   = w_strobe && (rxData == CMD_CLR);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_busySeen  <= 1'b0;
         memWe       <= 1'b0;
         memAddr     <= '0;
         memData     <= '0;
         engineStart <= 1'b0;
         frameReady  <= 1'b0;
         loading     <= 1'b0;
         errSticky   <= 1'b0;
      end else begin
         memWe       <= 1'b0;
         engineStart <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_isLoad) begin
                  r_state <= S_LOAD;
                  r_cnt   <= '0;
                  loading <= 1'b1;
               end else if (w_isStart) begin
                  errSticky <= 1'b1;
               end else if (w_isClr) begin
                  errSticky <= 1'b0;
               end
            end
            S_LOAD: begin
               if (w_csFall) begin
                  r_state   <= S_IDLE;
                  r_cnt     <= '0;
                  loading   <= 1'b0;
                  errSticky <= 1'b1;
               end else if (memWe && memAddr == LAST) begin
                  r_state    <= S_READY;
                  loading    <= 1'b0;
                  frameReady <= 1'b1;
               end else if (w_strobe) begin
                  memWe   <= 1'b1;
                  memAddr <= r_cnt;
                  memData <= rxData;
                  if (r_cnt != LAST) begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            S_READY: begin
               if (w_isStart) begin
                  r_state     <= S_RUN;
                  engineStart <= 1'b1;
                  frameReady  <= 1'b0;
                  r_busySeen  <= 1'b0;
               end else if (w_isLoad) begin
                  r_state    <= S_LOAD;
                  r_cnt      <= '0;
                  frameReady <= 1'b0;
                  loading    <= 1'b1;
               end else if (w_isClr) begin
                  errSticky <= 1'b0;
               end
            end
            S_RUN: begin
               // leave only after a full busy high-then-low cycle
               if (engineBusy) begin
                  r_busySeen <= 1'b1;
               end else if (r_busySeen) begin
                  r_state    <= S_IDLE;
                  r_busySeen <= 1'b0;
               end
               if (w_isLoad || w_isStart) begin
                  errSticky <= 1'b1;
               end else if (w_isClr) begin
                  errSticky <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/spi_frame_loader.md
# spi_frame_loader

Clock-domain controller between the SPI byte receiver and the image buffer RAM/edge-detection engine. It synchronises byte-complete indications from the SPI side and decodes a small command stream. It writes one image frame of pixel bytes into the buffer at sequential addresses, then hands the buffer to the edge engine with a start pulse. It owns buffer write access, and locks out loads while the engine runs.

## Interface
- IMG_W, 64, image width in pixels
- IMG_H, 48, image height in pixels
- ADDR_W, $clog2(IMG_W*IMG_H), buffer address width
- clk  input  1  system clock; all logic on rising edge
- nRst  input  1  asynchronous active-low reset
- rxData  input  8  received byte (SPI domain; stable while rxValid high)
- rxValid  input  1  byte-complete level from SPI receiver (asynchronous)
- csActive  input  1  SPI transaction active (asynchronous)
- engineBusy  input  1  edge engine running (clk domain)
- memWe  output  1  buffer write strobe
- memAddr  output  ADDR_W  buffer write address
- memData  output  8  buffer write data
- engineStart  output  1  one-cycle start pulse to edge engine
- frameReady  output  1  complete frame in buffer, not yet started
- loading  output  1  frame load in progress
- errSticky  output  1  protocol error flag

## Operation
- Sync: rxValid and csActive each pass through a 2-flop synchroniser. byteStrobe = rxValid_s2 & ~rxValid_s3, i.e. one cycle per rising edge. rxData is captured on byteStrobe.
- Commands (bytes received outside LOAD): 0xA5 LOAD, 0x5A START, 0xC3 CLRERR. Any other byte is ignored with no error.
- States: IDLE, LOAD, READY, RUN.
  - IDLE: LOAD → LOAD with pixel counter=0. START → errSticky=1, stay.
  - LOAD: every byteStrobe writes the byte to memAddr=counter, then counter+1. When the write to address IMG_W*IMG_H-1 completes → READY. Bytes are never decoded as commands here.
  - READY: START → engineStart pulse, then RUN. LOAD → reload (LOAD, counter=0, frameReady=0).
  - RUN: waits for engineBusy rise then fall → IDLE. LOAD or START → errSticky=1, ignored.
- Abort: a synchronised csActive fall while in LOAD → IDLE, counter=0, errSticky=1. Bytes already written stay in RAM but are not valid. csActive has no effect in other states.
- CLRERR clears errSticky in any state except LOAD, where it is pixel data.
- No writes are possible outside LOAD. Counter never exceeds IMG_W*IMG_H-1 and does not wrap.

## Timing
- Reset values: state IDLE, memWe 0, memAddr 0, memData 0, engineStart 0, frameReady 0, loading 0, errSticky 0, synchronisers 0, counter 0.
- Latency: byteStrobe is high during the cycle after the 2nd clk edge that samples rxValid high. memWe/memAddr/memData are registered and valid for exactly one cycle after byteStrobe.
- Minimum byte spacing: rxValid must remain low for at least 3 clk periods and high for at least 3 clk periods. Faster streams are out of spec.
- loading=1 exactly while in LOAD. frameReady=1 exactly while in READY, asserted the cycle after the final memWe.
- engineStart is registered, one cycle wide, in the cycle after the START byteStrobe. The state is RUN from that same cycle.
- If engineBusy falls while still in RUN, the return to IDLE happens on the next edge. If engineBusy never rises, the block stays in RUN; recovery is by reset only.
- Simultaneous csActive-fall and byteStrobe in LOAD: abort takes priority and the byte is not written.
- Reset mid-load: all outputs return to reset values asynchronously, and memWe drops immediately.

## Test plan
Bench uses IMG_W=4, IMG_H=2 (8 pixels).
- Normal load: send 0xA5 then 0x10..0x17 → memWe pulses at addr 0..7 with data 0x10..0x17; frameReady=1 one cycle after the last write; loading=0.
- Start: from READY send 0x5A → single engineStart pulse; engineBusy high 20 cycles then low → IDLE, frameReady=0, errSticky=0.
- Data vs command: send 0xA5, then 0x5A,0xA5,0xC3,0,0,0,0,0 → all 8 bytes written as pixels at addr 0..7; no engineStart; READY reached.
- Abort: send 0xA5 and 3 pixels, then drop csActive → IDLE, errSticky=1, no further memWe. CLRERR then sets errSticky=0.
- Lockout: during RUN send 0xA5 and 0x11 → no memWe, errSticky=1, stays in RUN until engineBusy falls.
- Async reset: assert nRst low mid-load after 5 pixels → all outputs 0 immediately. After release, 0xA5 plus 8 bytes writes from addr 0.
